nexys_starship_spawn_ctrl: RTL and testbench
============================================

NEXYS_STARSHIP_SPAWN_CTRL -- requirements
Module: nexys_starship_spawn_ctrl

Interface
REQ-001 Parameter MONSTER_TIME, default 8'd20, ticks a spawned monster survives before destroying the ship.
REQ-002 Parameter COOL_TIME, default 8'd4, ticks a side stays blocked after a kill.
REQ-003 Parameter REPAIR_TIME, default 8'd30, ticks allowed to complete a pending repair.
REQ-004 Clk  in  1  single system clock; all state changes on posedge Clk.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  game running; when 0, no new spawns or repair requests and all timers hold.
REQ-007 tick  in  1  one-cycle game-time pulse; timers decrement only on cycles where tick=1.
REQ-008 top_random, btm_random, left_random, right_random  in  1 each  per-side spawn request flags from the PRNG.
REQ-009 TR_random, BR_random, LR_random, RR_random  in  1 each  per-side repair request flags from the PRNG.
REQ-010 random_hex  in  4  PRNG hex digit, captured as the repair code.
REQ-011 top_kill, btm_kill, left_kill, right_kill  in  1 each  one-cycle player shot pulse per side.
REQ-012 repair_submit  in  1  one-cycle pulse; repair_hex is valid this cycle.
REQ-013 repair_hex  in  4  player-entered repair code.
REQ-014 top_monster, btm_monster, left_monster, right_monster  out  1 each  side in ACTIVE.
REQ-015 repair_pending  out  1  a repair is outstanding.
REQ-016 repair_side  out  2  repair side: 0 top, 1 btm, 2 left, 3 right.
REQ-017 repair_code  out  4  hex digit the player must enter.
REQ-018 repair_ok, repair_err  out  1 each  one-cycle result pulses for a submit.
REQ-019 score  out  8  kill count.
REQ-020 game_over  out  1  sticky loss flag.

Function
REQ-021 Each side SHALL run an independent FSM: IDLE, ACTIVE, COOLDOWN, with an 8-bit timer.
REQ-022 IDLE->ACTIVE: side flag=1, enable=1, game_over=0; timer loaded with MONSTER_TIME.
REQ-023 ACTIVE: kill pulse -> COOLDOWN, timer=COOL_TIME, score+1 (saturate at 255).
REQ-024 ACTIVE, tick=1, no kill: timer==1 -> game_over set at that edge; else timer-1; expiry therefore occurs on the MONSTER_TIME-th tick.
REQ-025 Kill and expiring tick in the same cycle: kill wins; game_over not set.
REQ-026 COOLDOWN, tick=1: timer==1 -> IDLE; else timer-1; spawn flags ignored.
REQ-027 Kill pulses in IDLE or COOLDOWN SHALL be ignored (no score change).
REQ-028 Kills on several sides in the same cycle SHALL each add 1 to score, saturating at 255.
REQ-029 Repair slot, when not pending and enable=1 and game_over=0: first asserted flag by priority TR>BR>LR>RR SHALL latch repair_side, repair_code=random_hex, repair timer=REPAIR_TIME, repair_pending=1 next edge.
REQ-030 Repair flags while pending SHALL be ignored.
REQ-031 repair_submit while pending: repair_hex==repair_code -> repair_pending=0, repair_ok pulse; else repair_err pulse, still pending, timer unchanged.
REQ-032 repair_submit while not pending SHALL produce no pulse.
REQ-033 Pending repair, tick=1, no matching submit: timer==1 -> game_over; else timer-1; a matching submit wins over expiry in the same cycle.
REQ-034 game_over=1 SHALL freeze all FSMs, timers, score and repair state; outputs hold; cleared only by Reset.
REQ-035 enable=0 SHALL hold all state; kills and submits still processed.

Reset
REQ-036 Reset=1 SHALL asynchronously force all FSMs IDLE, all timers 0, all outputs 0 (score 0, repair_side 0, repair_code 0, game_over 0); applies mid-operation.

Verification
REQ-037 MONSTER_TIME=3: top_random=1 one cycle -> top_monster=1 next edge; 3 ticks, no kill -> game_over=1 on the third tick edge, and it stays 1.
REQ-038 left ACTIVE, left_kill with the third (expiring) tick -> game_over=0, score=1, left in COOLDOWN; left_random ignored for COOL_TIME ticks, then spawn accepted.
REQ-039 TR_random and RR_random both high with random_hex=4'hA -> repair_side=0, repair_code=A; submit 4'h3 -> repair_err pulse; submit 4'hA -> repair_ok pulse, repair_pending=0.
REQ-040 score=255, kill -> score stays 255; two sides killed same cycle from 10 -> 12.
REQ-041 Reset asserted mid-ACTIVE with pending repair -> all outputs 0 immediately, without waiting for a clock edge.
REQ-042 enable=0 for 5 ticks while ACTIVE -> timer unchanged, no new spawns; re-enable -> countdown resumes from the held value.

Source files
------------

// File: rtl/nexys_starship_spawn_ctrl.sv
// nexys_starship_spawn_ctrl
//
// Purpose: game-logic core for the starship defence game. Each of the four
// sides (top, btm, left, right) runs its own spawn/kill FSM with an 8-bit
// countdown timer, and a single repair slot asks the player to type a hex
// code before its own timer runs out. A monster or repair timer expiring sets
// the sticky game_over flag, which freezes the whole game until Reset.
//
// Ports:
//   Clk, Reset          - system clock, asynchronous active-high reset
//   enable              - game running; when low, timers hold and nothing spawns
//   tick                - one-cycle game-time pulse; timers count on it
//   *_random            - per-side spawn request flags from the PRNG
//   TR/BR/LR/RR_random  - per-side repair request flags from the PRNG
//   random_hex          - PRNG hex digit captured as the repair code
//   *_kill              - one-cycle player shot pulse per side
//   repair_submit/hex   - player repair entry, hex valid with the pulse
//   *_monster           - side currently has a live monster
//   repair_pending/side/code - outstanding repair and what must be entered
//   repair_ok/err       - one-cycle result pulses for a submit
//   score               - saturating kill count
//   game_over           - sticky loss flag
module nexys_starship_spawn_ctrl #(
  parameter logic [7:0] MONSTER_TIME = 8'd20,
  parameter logic [7:0] COOL_TIME    = 8'd4,
  parameter logic [7:0] REPAIR_TIME  = 8'd30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic       tick,
  input  logic       top_random,
  input  logic       btm_random,
  input  logic       left_random,
  input  logic       right_random,
  input  logic       TR_random,
  input  logic       BR_random,
  input  logic       LR_random,
  input  logic       RR_random,
  input  logic [3:0] random_hex,
  input  logic       top_kill,
  input  logic       btm_kill,
  input  logic       left_kill,
  input  logic       right_kill,
  input  logic       repair_submit,
  input  logic [3:0] repair_hex,
  output logic       top_monster,
  output logic       btm_monster,
  output logic       left_monster,
  output logic       right_monster,
  output logic       repair_pending,
  output logic [1:0] repair_side,
  output logic [3:0] repair_code,
  output logic       repair_ok,
  output logic       repair_err,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} side_state_t;

  side_state_t state_q [4];
  side_state_t state_d [4];
  logic [7:0]  timer_q [4];
  logic [7:0]  timer_d [4];

  logic [7:0] score_d;
  logic       game_over_d;
  logic       pending_d;
  logic [1:0] side_d;
  logic [3:0] code_d;
  logic [7:0] repair_timer_q, repair_timer_d;
  logic       ok_d, err_d;

  logic [3:0] spawn_req, kill_req;
  logic       run, step, expire, match;
  logic [2:0] kill_cnt;
  logic [8:0] score_sum;

  assign spawn_req = {right_random, left_random, btm_random, top_random};
  assign kill_req  = {right_kill, left_kill, btm_kill, top_kill};
  assign run       = enable && !game_over;
  assign step      = run && tick;
  assign match     = repair_submit && (repair_hex == repair_code);

  // Next-state logic for the four side FSMs, the repair slot and the score.
  // Nothing moves once game_over is set. Kills and submits bypass enable so
  // the player can still act while the game clock is paused. Any expiry is
  // gathered into one flag that makes game_over sticky.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
    end
    kill_cnt       = 3'd0;
    expire         = 1'b0;
    pending_d      = repair_pending;
    side_d         = repair_side;
    code_d         = repair_code;
    repair_timer_d = repair_timer_q;
    ok_d           = 1'b0;
    err_d          = 1'b0;

    if (!game_over) begin
      for (int i = 0; i < 4; i++) begin
        case (state_q[i])
          IDLE: begin
            if (run && spawn_req[i]) begin
              state_d[i] = ACTIVE;
              timer_d[i] = MONSTER_TIME;
            end
          end
          ACTIVE: begin
            // A kill beats an expiring tick in the same cycle.
            if (kill_req[i]) begin
              state_d[i] = COOLDOWN;
              timer_d[i] = COOL_TIME;
              kill_cnt   = kill_cnt + 3'd1;
            end else if (step) begin
              if (timer_q[i] == 8'd1) expire = 1'b1;
              else timer_d[i] = timer_q[i] - 8'd1;
            end
          end
          COOLDOWN: begin
            if (step) begin
              if (timer_q[i] == 8'd1) begin
                state_d[i] = IDLE;
                timer_d[i] = 8'd0;
              end else begin
                timer_d[i] = timer_q[i] - 8'd1;
              end
            end
          end
          default: begin
            state_d[i] = IDLE;
            timer_d[i] = 8'd0;
          end
        endcase
      end

      if (repair_pending) begin
        if (repair_submit) begin
          if (match) begin
            pending_d = 1'b0;
            ok_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        // A correct submit beats an expiring tick in the same cycle.
        if (!match && step) begin
          if (repair_timer_q == 8'd1) expire = 1'b1;
          else repair_timer_d = repair_timer_q - 8'd1;
        end
      end else if (run && (TR_random || BR_random || LR_random || RR_random)) begin
        pending_d      = 1'b1;
        code_d         = random_hex;
        repair_timer_d = REPAIR_TIME;
        if (TR_random)      side_d = 2'd0;
        else if (BR_random) side_d = 2'd1;
        else if (LR_random) side_d = 2'd2;
        else                side_d = 2'd3;
      end
    end

    // Several kills in one cycle all count, clamped at 255.
    score_sum   = {1'b0, score} + {6'd0, kill_cnt};
    score_d     = score_sum[8] ? 8'hFF : score_sum[7:0];
    game_over_d = game_over || expire;
  end

  // State register for everything; reset clears it without waiting for Clk.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= 8'd0;
      end
      score          <= 8'd0;
      game_over      <= 1'b0;
      repair_pending <= 1'b0;
      repair_side    <= 2'd0;
      repair_code    <= 4'd0;
      repair_timer_q <= 8'd0;
      repair_ok      <= 1'b0;
      repair_err     <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      score          <= score_d;
      game_over      <= game_over_d;
      repair_pending <= pending_d;
      repair_side    <= side_d;
      repair_code    <= code_d;
      repair_timer_q <= repair_timer_d;
      repair_ok      <= ok_d;
      repair_err     <= err_d;
    end
  end

  assign top_monster   = (state_q[0] == ACTIVE);
  assign btm_monster   = (state_q[1] == ACTIVE);
  assign left_monster  = (state_q[2] == ACTIVE);
  assign right_monster = (state_q[3] == ACTIVE);

endmodule

// File: tb/tb_nexys_starship_spawn_ctrl.sv
// tb_nexys_starship_spawn_ctrl
//
// Purpose: directed self-checking bench for nexys_starship_spawn_ctrl, built
// with short timers (MONSTER_TIME=3, COOL_TIME=4, REPAIR_TIME=6) so expiry,
// cooldown, repair, freeze, enable-hold, score saturation and asynchronous
// reset can all be walked through cycle by cycle.
//
// Ports: none (top-level bench).
module tb_nexys_starship_spawn_ctrl;

  logic       Clk, Reset, enable, tick;
  logic       top_random, btm_random, left_random, right_random;
  logic       TR_random, BR_random, LR_random, RR_random;
  logic [3:0] random_hex;
  logic       top_kill, btm_kill, left_kill, right_kill;
  logic       repair_submit;
  logic [3:0] repair_hex;
  logic       top_monster, btm_monster, left_monster, right_monster;
  logic       repair_pending;
  logic [1:0] repair_side;
  logic [3:0] repair_code;
  logic       repair_ok, repair_err;
  logic [7:0] score;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  nexys_starship_spawn_ctrl #(
    .MONSTER_TIME(8'd3),
    .COOL_TIME(8'd4),
    .REPAIR_TIME(8'd6)
  ) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .tick(tick),
    .top_random(top_random), .btm_random(btm_random),
    .left_random(left_random), .right_random(right_random),
    .TR_random(TR_random), .BR_random(BR_random),
    .LR_random(LR_random), .RR_random(RR_random),
    .random_hex(random_hex),
    .top_kill(top_kill), .btm_kill(btm_kill),
    .left_kill(left_kill), .right_kill(right_kill),
    .repair_submit(repair_submit), .repair_hex(repair_hex),
    .top_monster(top_monster), .btm_monster(btm_monster),
    .left_monster(left_monster), .right_monster(right_monster),
    .repair_pending(repair_pending), .repair_side(repair_side),
    .repair_code(repair_code), .repair_ok(repair_ok), .repair_err(repair_err),
    .score(score), .game_over(game_over)
  );

  // 10-time-unit clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock; outputs are sampled 1 unit after the rising edge.
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_top"},     32'(top_monster),    32'd0);
    checkOutput({pfx, "_btm"},     32'(btm_monster),    32'd0);
    checkOutput({pfx, "_left"},    32'(left_monster),   32'd0);
    checkOutput({pfx, "_right"},   32'(right_monster),  32'd0);
    checkOutput({pfx, "_pending"}, 32'(repair_pending), 32'd0);
    checkOutput({pfx, "_side"},    32'(repair_side),    32'd0);
    checkOutput({pfx, "_code"},    32'(repair_code),    32'd0);
    checkOutput({pfx, "_ok"},      32'(repair_ok),      32'd0);
    checkOutput({pfx, "_err"},     32'(repair_err),     32'd0);
    checkOutput({pfx, "_score"},   32'(score),          32'd0);
    checkOutput({pfx, "_gameover"},32'(game_over),      32'd0);
  endtask

  task automatic pulseReset();
    Reset = 1'b1;
    applyStimulus();
    Reset = 1'b0;
  endtask

  // Spawn the masked sides, kill them all in one cycle, then wait out cooldown.
  task automatic killRound(input logic [3:0] mask);
    {right_random, left_random, btm_random, top_random} = mask;
    applyStimulus();
    {right_random, left_random, btm_random, top_random} = 4'b0000;
    {right_kill, left_kill, btm_kill, top_kill} = mask;
    applyStimulus();
    {right_kill, left_kill, btm_kill, top_kill} = 4'b0000;
    tick = 1'b1;
    repeat (4) applyStimulus();
    tick = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; enable = 1'b1; tick = 1'b0;
    {top_random, btm_random, left_random, right_random} = 4'b0000;
    {TR_random, BR_random, LR_random, RR_random} = 4'b0000;
    {top_kill, btm_kill, left_kill, right_kill} = 4'b0000;
    random_hex = 4'h0; repair_submit = 1'b0; repair_hex = 4'h0;

    // Reset state.
    #1;
    checkAllZero("rst");
    applyStimulus();
    applyStimulus();
    Reset = 1'b0;

    // Monster expiry on the third tick; game_over sticks and freezes play.
    top_random = 1'b1;
    applyStimulus();
    top_random = 1'b0;
    checkOutput("spawn_top", 32'(top_monster), 32'd1);
    tick = 1'b1;
    applyStimulus();
    checkOutput("exp_tick1", 32'(game_over), 32'd0);
    applyStimulus();
    checkOutput("exp_tick2", 32'(game_over), 32'd0);
    applyStimulus();
    checkOutput("exp_tick3", 32'(game_over), 32'd1);
    applyStimulus();
    applyStimulus();
    tick = 1'b0;
    checkOutput("exp_sticky", 32'(game_over), 32'd1);
    btm_random = 1'b1;
    applyStimulus();
    btm_random = 1'b0;
    checkOutput("frozen_spawn", 32'(btm_monster), 32'd0);
    top_kill = 1'b1;
    applyStimulus();
    top_kill = 1'b0;
    checkOutput("frozen_score", 32'(score), 32'd0);
    checkOutput("frozen_top", 32'(top_monster), 32'd1);
    pulseReset();
    checkOutput("clear_gameover", 32'(game_over), 32'd0);

    // Kill beats the expiring tick; cooldown blocks respawn for 4 ticks.
    left_random = 1'b1;
    applyStimulus();
    left_random = 1'b0;
    checkOutput("spawn_left", 32'(left_monster), 32'd1);
    tick = 1'b1;
    applyStimulus();
    applyStimulus();
    left_kill = 1'b1;
    applyStimulus();
    left_kill = 1'b0;
    checkOutput("killwin_go", 32'(game_over), 32'd0);
    checkOutput("killwin_score", 32'(score), 32'd1);
    checkOutput("killwin_left", 32'(left_monster), 32'd0);
    left_random = 1'b1;
    repeat (4) applyStimulus();
    tick = 1'b0;
    checkOutput("cool_blocked", 32'(left_monster), 32'd0);
    applyStimulus();
    left_random = 1'b0;
    checkOutput("cool_respawn", 32'(left_monster), 32'd1);
    left_kill = 1'b1;
    applyStimulus();
    checkOutput("kill2_score", 32'(score), 32'd2);
    applyStimulus();
    left_kill = 1'b0;
    checkOutput("cool_kill_ignored", 32'(score), 32'd2);
    tick = 1'b1;
    repeat (4) applyStimulus();
    tick = 1'b0;

    // enable=0 holds the timer and blocks spawns; countdown resumes after.
    right_random = 1'b1;
    applyStimulus();
    right_random = 1'b0;
    checkOutput("spawn_right", 32'(right_monster), 32'd1);
    tick = 1'b1;
    applyStimulus();
    enable = 1'b0;
    top_random = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("hold_right", 32'(right_monster), 32'd1);
    checkOutput("hold_nospawn", 32'(top_monster), 32'd0);
    checkOutput("hold_go", 32'(game_over), 32'd0);
    enable = 1'b1;
    top_random = 1'b0;
    applyStimulus();
    checkOutput("resume_tick1", 32'(game_over), 32'd0);
    applyStimulus();
    tick = 1'b0;
    checkOutput("resume_tick2", 32'(game_over), 32'd1);
    pulseReset();

    // Repair priority, wrong and right codes, ignored requests and submits.
    TR_random = 1'b1; RR_random = 1'b1; random_hex = 4'hA;
    applyStimulus();
    TR_random = 1'b0; RR_random = 1'b0;
    checkOutput("rep_pending", 32'(repair_pending), 32'd1);
    checkOutput("rep_side_tr", 32'(repair_side), 32'd0);
    checkOutput("rep_code_a", 32'(repair_code), 32'hA);
    BR_random = 1'b1; random_hex = 4'h5;
    applyStimulus();
    BR_random = 1'b0;
    checkOutput("rep_ignored_side", 32'(repair_side), 32'd0);
    checkOutput("rep_ignored_code", 32'(repair_code), 32'hA);
    repair_submit = 1'b1; repair_hex = 4'h3;
    applyStimulus();
    repair_submit = 1'b0;
    checkOutput("rep_err", 32'(repair_err), 32'd1);
    checkOutput("rep_err_ok", 32'(repair_ok), 32'd0);
    checkOutput("rep_err_pending", 32'(repair_pending), 32'd1);
    applyStimulus();
    checkOutput("rep_err_pulse", 32'(repair_err), 32'd0);
    repair_submit = 1'b1; repair_hex = 4'hA;
    applyStimulus();
    repair_submit = 1'b0;
    checkOutput("rep_ok", 32'(repair_ok), 32'd1);
    checkOutput("rep_ok_err", 32'(repair_err), 32'd0);
    checkOutput("rep_ok_pending", 32'(repair_pending), 32'd0);
    applyStimulus();
    checkOutput("rep_ok_pulse", 32'(repair_ok), 32'd0);
    repair_submit = 1'b1;
    applyStimulus();
    repair_submit = 1'b0;
    checkOutput("rep_idle_ok", 32'(repair_ok), 32'd0);
    checkOutput("rep_idle_err", 32'(repair_err), 32'd0);

    // LR over RR; matching submit beats expiry; unanswered repair ends game.
    LR_random = 1'b1; RR_random = 1'b1; random_hex = 4'h7;
    applyStimulus();
    LR_random = 1'b0; RR_random = 1'b0;
    checkOutput("rep_side_lr", 32'(repair_side), 32'd2);
    checkOutput("rep_code_7", 32'(repair_code), 32'h7);
    tick = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("rep_t5_go", 32'(game_over), 32'd0);
    repair_submit = 1'b1; repair_hex = 4'h7;
    applyStimulus();
    repair_submit = 1'b0; tick = 1'b0;
    checkOutput("rep_win_go", 32'(game_over), 32'd0);
    checkOutput("rep_win_ok", 32'(repair_ok), 32'd1);
    checkOutput("rep_win_pending", 32'(repair_pending), 32'd0);
    RR_random = 1'b1; random_hex = 4'hC;
    applyStimulus();
    RR_random = 1'b0;
    checkOutput("rep_side_rr", 32'(repair_side), 32'd3);
    checkOutput("rep_code_c", 32'(repair_code), 32'hC);
    tick = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("rep_exp_t5", 32'(game_over), 32'd0);
    applyStimulus();
    tick = 1'b0;
    checkOutput("rep_exp_t6", 32'(game_over), 32'd1);
    pulseReset();

    // Asynchronous reset mid-game with a live monster and pending repair.
    btm_random = 1'b1;
    applyStimulus();
    btm_random = 1'b0;
    btm_kill = 1'b1;
    applyStimulus();
    btm_kill = 1'b0;
    checkOutput("pre_rst_score", 32'(score), 32'd1);
    top_random = 1'b1; TR_random = 1'b1; random_hex = 4'hF;
    applyStimulus();
    top_random = 1'b0; TR_random = 1'b0;
    checkOutput("pre_rst_top", 32'(top_monster), 32'd1);
    checkOutput("pre_rst_code", 32'(repair_code), 32'hF);
    #2;
    Reset = 1'b1;
    #1;
    checkAllZero("async_rst");
    applyStimulus();
    Reset = 1'b0;

    // Multi-side kills add up; score saturates at 255.
    killRound(4'b1111);
    killRound(4'b1111);
    checkOutput("score_8", 32'(score), 32'd8);
    killRound(4'b0011);
    checkOutput("score_10", 32'(score), 32'd10);
    killRound(4'b0011);
    checkOutput("score_12", 32'(score), 32'd12);
    repeat (60) killRound(4'b1111);
    checkOutput("score_252", 32'(score), 32'd252);
    killRound(4'b0111);
    checkOutput("score_255", 32'(score), 32'd255);
    killRound(4'b0001);
    checkOutput("score_sat1", 32'(score), 32'd255);
    killRound(4'b1111);
    checkOutput("score_sat4", 32'(score), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
